// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I field-level encoder: request op codes,
// base opcodes, funct fields and the field-packing helpers.
package rv_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_LUI  = 4'd8,
        OP_LI   = 4'd9
    } enc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_HOLD_LUI = 2'd2
    } enc_state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] enc_i_type(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [6:0]  opc
    );
        return {imm, rs1, f3, rd, opc};
    endfunction

    // True when the value sign-extends from 12 bits, i.e. lies in [-2048, 2047].
    function automatic logic fits_simm12(input logic [31:0] imm);
        return (imm[31:11] == {21{1'b0}}) || (imm[31:11] == {21{1'b1}});
    endfunction

    function automatic logic fits_simm13(input logic [31:0] imm);
        return (imm[31:12] == {20{1'b0}}) || (imm[31:12] == {20{1'b1}});
    endfunction

endpackage

// File: rtl/rv_enc_fmt.sv
// Combinational single-word formatter: packs one instruction from its fields
// and substitutes a NOP with err_o set when the request cannot be encoded.
module rv_enc_fmt
    import rv_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic [31:0] word_s;
    logic        bad_s;

    // Field packing per op, flagging out-of-range immediates and unknown ops.
    always_comb begin
        word_s = NOP_INSTR;
        bad_s  = 1'b0;
        case (op_i)
            OP_ADD:  word_s = {F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OPC_OP};
            OP_SUB:  word_s = {F7_SUB,  rs2_i, rs1_i, F3_ADD_SUB, rd_i, OPC_OP};
            OP_AND:  word_s = {F7_BASE, rs2_i, rs1_i, F3_AND,     rd_i, OPC_OP};
            OP_OR:   word_s = {F7_BASE, rs2_i, rs1_i, F3_OR,      rd_i, OPC_OP};
            OP_ADDI: begin
                if (fits_simm12(imm_i)) begin
                    word_s = enc_i_type(imm_i[11:0], rs1_i, F3_ADD_SUB, rd_i, OPC_OP_IMM);
                end else begin
                    bad_s = 1'b1;
                end
            end
            OP_LW: begin
                if (fits_simm12(imm_i)) begin
                    word_s = enc_i_type(imm_i[11:0], rs1_i, F3_WORD, rd_i, OPC_LOAD);
                end else begin
                    bad_s = 1'b1;
                end
            end
            OP_SW: begin
                if (fits_simm12(imm_i)) begin
                    word_s = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
                end else begin
                    bad_s = 1'b1;
                end
            end
            OP_BEQ: begin
                // Branch offsets are halfword-aligned; bit 0 is never encoded.
                if (fits_simm13(imm_i) && (imm_i[0] == 1'b0)) begin
                    word_s = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                              imm_i[4:1], imm_i[11], OPC_BRANCH};
                end else begin
                    bad_s = 1'b1;
                end
            end
            OP_LUI: begin
                if (imm_i[31:20] == 12'd0) begin
                    word_s = {imm_i[19:0], rd_i, OPC_LUI};
                end else begin
                    bad_s = 1'b1;
                end
            end
            default: bad_s = 1'b1;
        endcase
        instr_o = bad_s ? NOP_INSTR : word_s;
        err_o   = bad_s;
    end

endmodule

// File: rtl/rv_encoder.sv
// Streaming RV32I encoder: accepts field-level requests, expands LI into
// LUI+ADDI when needed and presents registered words on a valid/ready port.
module rv_encoder
    import rv_pkg::*;
#(
    parameter bit LI_COMPRESS = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_err_o,
    output logic        instr_last_o
);

    enc_state_e  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        err_q,   err_d;
    logic        last_q,  last_d;
    logic [11:0] lo_q,    lo_d;
    logic [4:0]  rd_q,    rd_d;

    logic [3:0]  fmt_op_s;
    logic [4:0]  fmt_rs1_s;
    logic [31:0] fmt_imm_s;
    logic [31:0] fmt_instr_s;
    logic        fmt_err_s;
    logic        two_word_s;
    logic [19:0] li_hi_s;
    logic [31:0] addi_word_s;
    logic        accept_s;
    logic        drain_s;

    // Adding 0x800 before the >>12 only carries into bit 12 when imm[11] is set.
    assign li_hi_s     = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
    assign addi_word_s = enc_i_type(lo_q, rd_q, F3_ADD_SUB, rd_q, OPC_OP_IMM);

    assign req_ready_o   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && instr_ready_i);
    assign accept_s      = req_valid_i && req_ready_o;
    assign drain_s       = valid_q && instr_ready_i;

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_err_o   = err_q;
    assign instr_last_o  = last_q;

    // Map LI onto the first word it emits; everything else passes straight through.
    always_comb begin
        fmt_op_s   = req_op_i;
        fmt_rs1_s  = req_rs1_i;
        fmt_imm_s  = req_imm_i;
        two_word_s = 1'b0;
        if (req_op_i == OP_LI) begin
            if (LI_COMPRESS && fits_simm12(req_imm_i)) begin
                fmt_op_s  = OP_ADDI;
                fmt_rs1_s = 5'd0;
            end else begin
                fmt_op_s   = OP_LUI;
                fmt_imm_s  = {12'd0, li_hi_s};
                two_word_s = !(LI_COMPRESS && (req_imm_i[11:0] == 12'd0));
            end
        end else begin
            two_word_s = 1'b0;
        end
    end

    rv_enc_fmt u_fmt (
        .op_i    (fmt_op_s),
        .rd_i    (req_rd_i),
        .rs1_i   (fmt_rs1_s),
        .rs2_i   (req_rs2_i),
        .imm_i   (fmt_imm_s),
        .instr_o (fmt_instr_s),
        .err_o   (fmt_err_s)
    );

    // Next-state and output-register logic for the word holding FSM.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        last_d  = last_q;
        lo_d    = lo_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s) begin
                    // In HOLD an accept implies a drain, so the new word overwrites in place.
                    instr_d = fmt_instr_s;
                    err_d   = fmt_err_s;
                    valid_d = 1'b1;
                    if (two_word_s) begin
                        state_d = ST_HOLD_LUI;
                        last_d  = 1'b0;
                        lo_d    = req_imm_i[11:0];
                        rd_d    = req_rd_i;
                    end else begin
                        state_d = ST_HOLD;
                        last_d  = 1'b1;
                    end
                end else if (drain_s) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD_LUI: begin
                if (drain_s) begin
                    state_d = ST_HOLD;
                    instr_d = addi_word_s;
                    err_d   = 1'b0;
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_HOLD_LUI;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                err_d   = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending ADDI at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            lo_q    <= 12'd0;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_rv_encoder.sv
// Directed self-checking bench for rv_encoder with both LI_COMPRESS settings.
module tb_rv_encoder;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [4:0]  req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
    logic [31:0] req_imm = 32'd0;
    logic        instr_ready = 1'b1, instr_ready0 = 1'b1;
    logic        req_ready, req_ready0;
    logic        ivalid, ivalid0, ierr, ierr0, ilast, ilast0;
    logic [31:0] instr, instr0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, word;
        logic        err;
    } fmt_vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] imm, w0;
        logic        last0, two;
        logic [31:0] w1;
    } li_vec_t;

    always #5 clk = ~clk;

    rv_encoder dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .req_imm_i(req_imm), .instr_valid_o(ivalid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_err_o(ierr), .instr_last_o(ilast)
    );

    rv_encoder #(.LI_COMPRESS(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
        .req_op_i(req_op), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .req_imm_i(req_imm), .instr_valid_o(ivalid0), .instr_ready_i(instr_ready0),
        .instr_o(instr0), .instr_err_o(ierr0), .instr_last_o(ilast0)
    );

    task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({ivalid, instr, ierr, ilast, req_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset: got v=%b i=%h e=%b l=%b r=%b, want v=0 i=0 e=0 l=0 r=1",
                     ivalid, instr, ierr, ilast, req_ready);
        else n_pass++;
        @(negedge clk) rst_ni = 1'b1;
    endtask

    task automatic test_back_to_back;
        instr_ready = 1'b1;
        @(negedge clk) set_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0); req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ivalid, instr, ilast} !== {1'b1, 32'h002081B3, 1'b1})
            $display("FAIL b2b_add: got v=%b i=%h l=%b, want 1 002081b3 1", ivalid, instr, ilast);
        else n_pass++;
        set_req(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        n_checks++;
        if ({ivalid, instr, ilast} !== {1'b1, 32'h402081B3, 1'b1})
            $display("FAIL b2b_sub: got v=%b i=%h l=%b, want 1 402081b3 1", ivalid, instr, ilast);
        else n_pass++;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ivalid !== 1'b0) $display("FAIL b2b_idle: got valid=%b, want 0", ivalid);
        else n_pass++;
    endtask

    task automatic test_li_split;
        @(negedge clk) set_req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345678); req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ivalid, instr, ilast, req_ready} !== {1'b1, 32'h123452B7, 1'b0, 1'b0})
            $display("FAIL li_lui: got v=%b i=%h l=%b r=%b, want 1 123452b7 0 0",
                     ivalid, instr, ilast, req_ready);
        else n_pass++;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ivalid, instr, ilast} !== {1'b1, 32'h67828293, 1'b1})
            $display("FAIL li_addi: got v=%b i=%h l=%b, want 1 67828293 1", ivalid, instr, ilast);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ivalid !== 1'b0) $display("FAIL li_idle: got valid=%b, want 0", ivalid);
        else n_pass++;
    endtask

    task automatic test_li_variants;
        li_vec_t v [6];
        v[0] = '{5'd5, 32'h00000800, 32'h000012B7, 1'b0, 1'b1, 32'h80028293};
        v[1] = '{5'd1, 32'hFFFFFFFF, 32'hFFF00093, 1'b1, 1'b0, 32'd0};
        v[2] = '{5'd1, 32'h00001000, 32'h000010B7, 1'b1, 1'b0, 32'd0};
        v[3] = '{5'd2, 32'h000007FF, 32'h7FF00113, 1'b1, 1'b0, 32'd0};
        v[4] = '{5'd2, 32'hFFFFF800, 32'h80000113, 1'b1, 1'b0, 32'd0};
        v[5] = '{5'd2, 32'hFFFFF7FF, 32'hFFFFF137, 1'b0, 1'b1, 32'h7FF10113};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk) set_req(OP_LI, v[k].rd, 5'd0, 5'd0, v[k].imm); req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            n_checks++;
            if ({ivalid, instr, ilast, ierr} !== {1'b1, v[k].w0, v[k].last0, 1'b0})
                $display("FAIL li_var%0d_w0: got v=%b i=%h l=%b e=%b, want 1 %h %b 0",
                         k, ivalid, instr, ilast, ierr, v[k].w0, v[k].last0);
            else n_pass++;
            if (v[k].two) begin
                @(negedge clk);
                n_checks++;
                if ({ivalid, instr, ilast} !== {1'b1, v[k].w1, 1'b1})
                    $display("FAIL li_var%0d_w1: got v=%b i=%h l=%b, want 1 %h 1",
                             k, ivalid, instr, ilast, v[k].w1);
                else n_pass++;
            end
            @(negedge clk);
            n_checks++;
            if (ivalid !== 1'b0) $display("FAIL li_var%0d_end: got valid=%b, want 0", k, ivalid);
            else n_pass++;
        end
    endtask

    task automatic test_li_no_compress;
        li_vec_t v [2];
        v[0] = '{5'd1, 32'hFFFFFFFF, 32'h000000B7, 1'b0, 1'b1, 32'hFFF08093};
        v[1] = '{5'd5, 32'h00001000, 32'h000012B7, 1'b0, 1'b1, 32'h00028293};
        instr_ready0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk) set_req(OP_LI, v[k].rd, 5'd0, 5'd0, v[k].imm); req_valid0 = 1'b1;
            @(negedge clk);
            req_valid0 = 1'b0;
            n_checks++;
            if ({ivalid0, instr0, ilast0, req_ready0} !== {1'b1, v[k].w0, 1'b0, 1'b0})
                $display("FAIL nocomp%0d_lui: got v=%b i=%h l=%b r=%b, want 1 %h 0 0",
                         k, ivalid0, instr0, ilast0, req_ready0, v[k].w0);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({ivalid0, instr0, ilast0, ierr0} !== {1'b1, v[k].w1, 1'b1, 1'b0})
                $display("FAIL nocomp%0d_addi: got v=%b i=%h l=%b e=%b, want 1 %h 1 0",
                         k, ivalid0, instr0, ilast0, ierr0, v[k].w1);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_formats;
        fmt_vec_t v [12];
        v[0]  = '{OP_AND,  5'd3, 5'd1, 5'd2, 32'd0,        32'h0020F1B3, 1'b0};
        v[1]  = '{OP_OR,   5'd3, 5'd1, 5'd2, 32'd0,        32'h0020E1B3, 1'b0};
        v[2]  = '{OP_SW,   5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0};
        v[3]  = '{OP_LW,   5'd5, 5'd2, 5'd0, 32'd16,       32'h01012283, 1'b0};
        v[4]  = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463, 1'b0};
        v[5]  = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd7,        32'h00000013, 1'b1};
        v[6]  = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFF000, 32'h80208063, 1'b0};
        v[7]  = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd4096,     32'h00000013, 1'b1};
        v[8]  = '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h00000013, 1'b1};
        v[9]  = '{OP_LUI,  5'd1, 5'd0, 5'd0, 32'h00100000, 32'h00000013, 1'b1};
        v[10] = '{OP_LUI,  5'd1, 5'd0, 5'd0, 32'h000FFFFF, 32'hFFFFF0B7, 1'b0};
        v[11] = '{4'hF,    5'd1, 5'd1, 5'd1, 32'd0,        32'h00000013, 1'b1};
        instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk) set_req(v[k].op, v[k].rd, v[k].rs1, v[k].rs2, v[k].imm);
            req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            n_checks++;
            if ({ivalid, instr, ierr, ilast} !== {1'b1, v[k].word, v[k].err, 1'b1})
                $display("FAIL fmt%0d: got v=%b i=%h e=%b l=%b, want 1 %h %b 1",
                         k, ivalid, instr, ierr, ilast, v[k].word, v[k].err);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        instr_ready = 1'b0;
        @(negedge clk) set_req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345678); req_valid = 1'b1;
        @(negedge clk) set_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({ivalid, instr, ilast, ierr, req_ready} !== {1'b1, 32'h123452B7, 1'b0, 1'b0, 1'b0})
                $display("FAIL stall%0d: got v=%b i=%h l=%b e=%b r=%b, want 1 123452b7 0 0 0",
                         k, ivalid, instr, ilast, ierr, req_ready);
            else n_pass++;
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ivalid, instr, ilast, req_ready} !== {1'b1, 32'h67828293, 1'b1, 1'b1})
            $display("FAIL stall_addi: got v=%b i=%h l=%b r=%b, want 1 67828293 1 1",
                     ivalid, instr, ilast, req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({ivalid, instr, ilast} !== {1'b1, 32'h002081B3, 1'b1})
            $display("FAIL stall_add: got v=%b i=%h l=%b, want 1 002081b3 1", ivalid, instr, ilast);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_li;
        instr_ready = 1'b0;
        @(negedge clk) set_req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345678); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({ivalid, ilast} !== {1'b1, 1'b0})
            $display("FAIL rst_pre: got v=%b l=%b, want 1 0", ivalid, ilast);
        else n_pass++;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({ivalid, instr, ierr, ilast, req_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL rst_async: got v=%b i=%h e=%b l=%b r=%b, want 0 0 0 0 1",
                     ivalid, instr, ierr, ilast, req_ready);
        else n_pass++;
        @(negedge clk);
        rst_ni = 1'b1;
        instr_ready = 1'b1;
        set_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({ivalid, instr, ilast, ierr} !== {1'b1, 32'h002081B3, 1'b1, 1'b0})
            $display("FAIL rst_post: got v=%b i=%h l=%b e=%b, want 1 002081b3 1 0",
                     ivalid, instr, ilast, ierr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ivalid !== 1'b0) $display("FAIL rst_stale: got valid=%b i=%h, want 0", ivalid, instr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_li_split();
        test_li_variants();
        test_li_no_compress();
        test_formats();
        test_backpressure();
        test_reset_mid_li();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
